pic_ctrl_sequencer: RTL and testbench

- Instruction fetch/decode/sequencing unit for the PIC16F-compatible core; the initiator side of the ALU control interface.
- Runs the four-phase Q1–Q4 instruction cycle, owns the PC and the instruction register, and drives ALU op/destination/bit-select/write-enables.
- Samples the ALU's zero and bit-test results to resolve conditional skips, and issues stack push/pop for CALL/RETURN/RETLW.
- Flushes the prefetched word on control-flow changes.

---
 rtl/pic_ctrl_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pic_ctrl_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ctrl_sequencer.sv
// pic_ctrl_sequencer
// Instruction fetch/decode/sequencing unit for a PIC16F-compatible core.
// Runs the Q1..Q4 instruction cycle, owns PC and IR, decodes IR into ALU
// controls, resolves conditional skips and drives stack push/pop.
//
// Ports:
//   clk, rst_n          core clock (one Q-phase per edge), async active-low reset
//   pm_addr / pm_data   program memory address (= PC) and returned word
//   q_phase             current phase, 0=Q1 .. 3=Q4
//   alu_op, alu_d       ALU operation and destination (0=W, 1=f)
//   alu_d_wr_en         result write request, Q4 only
//   alu_status_wr_en    status update request, Q4 only
//   alu_b_in            bit index IR[9:7]
//   alu_lit_sel         1 = operand from literal, 0 = from register file
//   literal, rf_addr    IR[7:0], IR[6:0]
//   alu_z_res           ALU zero result, sampled at end of Q4
//   alu_bit_test_res    ALU bit-test result, sampled at end of Q4
//   pclath_hi           PCLATH[4:3] for GOTO/CALL targets
//   stack_top           return address at top of stack
//   stack_push(_addr)   Q4 push strobe and return address (= PC)
//   stack_pop           Q4 pop strobe
module pic_ctrl_sequencer #(
    parameter logic [12:0] RESET_VECTOR = 13'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [12:0] pm_addr,
    input  logic [13:0] pm_data,
    output logic [1:0]  q_phase,
    output logic [3:0]  alu_op,
    output logic        alu_d,
    output logic        alu_d_wr_en,
    output logic        alu_status_wr_en,
    output logic [2:0]  alu_b_in,
    output logic        alu_lit_sel,
    output logic [7:0]  literal,
    output logic [6:0]  rf_addr,
    input  logic        alu_z_res,
    input  logic        alu_bit_test_res,
    input  logic [1:0]  pclath_hi,
    input  logic [12:0] stack_top,
    output logic        stack_push,
    output logic [12:0] stack_push_addr,
    output logic        stack_pop
);

    // ALU operation encodings shared with the ALU
    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_COM    = 4'd5;
    localparam logic [3:0] OP_INC    = 4'd6;
    localparam logic [3:0] OP_DEC    = 4'd7;
    localparam logic [3:0] OP_RRF    = 4'd8;
    localparam logic [3:0] OP_RLF    = 4'd9;
    localparam logic [3:0] OP_SWAPF  = 4'd10;
    localparam logic [3:0] OP_BC     = 4'd11;
    localparam logic [3:0] OP_BS     = 4'd12;
    localparam logic [3:0] OP_ZERO   = 4'd13;
    localparam logic [3:0] OP_PASSW  = 4'd14;
    localparam logic [3:0] OP_PASSLF = 4'd15;

    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

    phase_t      phase, phase_next;
    logic [12:0] pc, pc_next;
    logic [13:0] ir, ir_next;

    logic       dec_wr, dec_st;
    logic       is_fsz, is_btest, is_branch, is_call, is_return, is_retlw;
    logic       skip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= Q1;
            pc    <= RESET_VECTOR;
            ir    <= '0;
        end else begin
            phase <= phase_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // Decode: purely a function of IR, so stable over the whole cycle
    always_comb begin
        alu_op      = OP_PASSW;
        alu_d       = 1'b0;
        dec_wr      = 1'b0;
        dec_st      = 1'b0;
        alu_lit_sel = 1'b0;
        is_fsz      = 1'b0;
        is_btest    = 1'b0;
        is_branch   = 1'b0;
        is_call     = 1'b0;
        is_retlw    = 1'b0;
        is_return   = (ir == 14'h0008);
        unique case (ir[13:12])
            2'b00: begin
                alu_d  = ir[7];
                dec_wr = 1'b1;
                dec_st = 1'b1;
                unique case (ir[11:8])
                    4'h0: begin
                        // MOVWF writes f; NOP/RETURN/CLRWDT/SLEEP/RETFIE write nothing
                        alu_op = OP_PASSW;
                        alu_d  = 1'b1;
                        dec_wr = ir[7];
                        dec_st = 1'b0;
                    end
                    4'h1: alu_op = OP_ZERO;
                    4'h2: alu_op = OP_SUB;
                    4'h3: alu_op = OP_DEC;
                    4'h4: alu_op = OP_OR;
                    4'h5: alu_op = OP_AND;
                    4'h6: alu_op = OP_XOR;
                    4'h7: alu_op = OP_ADD;
                    4'h8: alu_op = OP_PASSLF;
                    4'h9: alu_op = OP_COM;
                    4'hA: alu_op = OP_INC;
                    4'hB: begin alu_op = OP_DEC; dec_st = 1'b0; is_fsz = 1'b1; end
                    4'hC: alu_op = OP_RRF;
                    4'hD: alu_op = OP_RLF;
                    4'hE: alu_op = OP_SWAPF;
                    4'hF: begin alu_op = OP_INC; dec_st = 1'b0; is_fsz = 1'b1; end
                endcase
            end
            2'b01: begin
                alu_d = 1'b1;
                unique case (ir[11:10])
                    2'b00: begin alu_op = OP_BC; dec_wr = 1'b1; end
                    2'b01: begin alu_op = OP_BS; dec_wr = 1'b1; end
                    2'b10: begin alu_op = OP_BC; is_btest = 1'b1; end
                    2'b11: begin alu_op = OP_BS; is_btest = 1'b1; end
                endcase
            end
            2'b10: begin
                is_branch = 1'b1;
                is_call   = ~ir[11];
            end
            2'b11: begin
                alu_lit_sel = 1'b1;
                dec_wr      = 1'b1;
                casez (ir[11:8])
                    4'b00??: alu_op = OP_PASSLF;
                    4'b01??: begin alu_op = OP_PASSLF; is_retlw = 1'b1; end
                    4'b1000: begin alu_op = OP_OR;  dec_st = 1'b1; end
                    4'b1001: begin alu_op = OP_AND; dec_st = 1'b1; end
                    4'b1010: begin alu_op = OP_XOR; dec_st = 1'b1; end
                    4'b110?: begin alu_op = OP_SUB; dec_st = 1'b1; end
                    4'b111?: begin alu_op = OP_ADD; dec_st = 1'b1; end
                    default: begin alu_op = OP_PASSLF; dec_wr = 1'b0; end
                endcase
            end
        endcase
    end

    assign skip = (is_fsz & alu_z_res) | (is_btest & alu_bit_test_res);

    // Phase advance and Q4 commit of PC/IR
    always_comb begin
        pc_next = pc;
        ir_next = ir;
        unique case (phase)
            Q1: phase_next = Q2;
            Q2: phase_next = Q3;
            Q3: phase_next = Q4;
            Q4: phase_next = Q1;
        endcase
        if (phase == Q4) begin
            if (is_branch) begin
                ir_next = '0;
                pc_next = {pclath_hi, ir[10:0]};
            end else if (is_return || is_retlw) begin
                ir_next = '0;
                pc_next = stack_top;
            end else if (skip) begin
                ir_next = '0;
                pc_next = pc + 13'd1;
            end else begin
                ir_next = pm_data;
                pc_next = pc + 13'd1;
            end
        end
    end

    assign q_phase          = phase;
    assign pm_addr          = pc;
    assign alu_b_in         = ir[9:7];
    assign literal          = ir[7:0];
    assign rf_addr          = ir[6:0];
    assign alu_d_wr_en      = dec_wr & (phase == Q4);
    assign alu_status_wr_en = dec_st & (phase == Q4);
    assign stack_push       = is_call & (phase == Q4);
    assign stack_push_addr  = pc;
    assign stack_pop        = (is_return | is_retlw) & (phase == Q4);

endmodule

// File: tb/tb_pic_ctrl_sequencer.sv
// tb_pic_ctrl_sequencer
// Directed bench for pic_ctrl_sequencer: a small program memory model feeds
// the sequencer while the bench drives ALU results and stack top by hand.
module tb_pic_ctrl_sequencer;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_DEC    = 4'd7;
    localparam logic [3:0] OP_BS     = 4'd12;
    localparam logic [3:0] OP_PASSW  = 4'd14;
    localparam logic [3:0] OP_PASSLF = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] pm_addr;
    logic [13:0] pm_data;
    logic [1:0]  q_phase;
    logic [3:0]  alu_op;
    logic        alu_d, alu_d_wr_en, alu_status_wr_en, alu_lit_sel;
    logic [2:0]  alu_b_in;
    logic [7:0]  literal;
    logic [6:0]  rf_addr;
    logic        alu_z_res, alu_bit_test_res;
    logic [1:0]  pclath_hi;
    logic [12:0] stack_top;
    logic        stack_push, stack_pop;
    logic [12:0] stack_push_addr;

    logic [13:0] mem [0:8191];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned clk_count = 0;
    int unsigned t0;

    always #5 clk = ~clk;
    always @(posedge clk) clk_count <= clk_count + 1;

    assign pm_data = mem[pm_addr];

    pic_ctrl_sequencer #(.RESET_VECTOR(13'h0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pm_addr          (pm_addr),
        .pm_data          (pm_data),
        .q_phase          (q_phase),
        .alu_op           (alu_op),
        .alu_d            (alu_d),
        .alu_d_wr_en      (alu_d_wr_en),
        .alu_status_wr_en (alu_status_wr_en),
        .alu_b_in         (alu_b_in),
        .alu_lit_sel      (alu_lit_sel),
        .literal          (literal),
        .rf_addr          (rf_addr),
        .alu_z_res        (alu_z_res),
        .alu_bit_test_res (alu_bit_test_res),
        .pclath_hi        (pclath_hi),
        .stack_top        (stack_top),
        .stack_push       (stack_push),
        .stack_push_addr  (stack_push_addr),
        .stack_pop        (stack_pop)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_q4();
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[13'h0000] = 14'h305A;   // MOVLW 0x5A
        mem[13'h0001] = 14'h07A0;   // ADDWF 0x20,1
        mem[13'h0005] = 14'h2923;   // GOTO 0x123
        mem[13'h1123] = 14'h2810;   // GOTO 0x010
        mem[13'h0010] = 14'h2040;   // CALL 0x040
        mem[13'h0040] = 14'h0008;   // RETURN
        mem[13'h0011] = 14'h0BA0;   // DECFSZ 0x20,1 (taken)
        mem[13'h0012] = 14'h07A0;   // skipped
        mem[13'h0013] = 14'h0BA0;   // DECFSZ 0x20,1 (not taken)
        mem[13'h0014] = 14'h3011;   // MOVLW 0x11
        mem[13'h0015] = 14'h1D03;   // BTFSS 0x03,2
        mem[13'h0016] = 14'h07A0;   // skipped
        mem[13'h0017] = 14'h1683;   // BSF 0x03,5
        mem[13'h0019] = 14'h07A0;   // ADDWF, interrupted by reset
        mem[13'h1FFF] = 14'h3077;   // MOVLW 0x77

        rst_n = 1'b0;
        alu_z_res = 1'b0;
        alu_bit_test_res = 1'b0;
        pclath_hi = 2'b10;
        stack_top = 13'h0011;

        repeat (3) tick();
        chk("rst_phase", 16'(q_phase), 16'd0);
        chk("rst_pm_addr", 16'(pm_addr), 16'h0000);
        chk("rst_d_wr", 16'(alu_d_wr_en), 16'd0);
        chk("rst_st_wr", 16'(alu_status_wr_en), 16'd0);
        chk("rst_push", 16'(stack_push), 16'd0);
        chk("rst_pop", 16'(stack_pop), 16'd0);
        rst_n = 1'b1;

        // cycle 1: NOP fetching the reset vector
        chk("c1_pm_addr", 16'(pm_addr), 16'h0000);
        to_q4();
        chk("c1_phase_q4", 16'(q_phase), 16'd3);
        chk("c1_d_wr", 16'(alu_d_wr_en), 16'd0);
        chk("c1_st_wr", 16'(alu_status_wr_en), 16'd0);
        tick();

        // cycle 2: MOVLW 0x5A
        chk("c2_pm_addr", 16'(pm_addr), 16'h0001);
        chk("c2_op", 16'(alu_op), 16'(OP_PASSLF));
        chk("c2_lit_sel", 16'(alu_lit_sel), 16'd1);
        chk("c2_d", 16'(alu_d), 16'd0);
        chk("c2_literal", 16'(literal), 16'h005A);
        chk("c2_d_wr_q1", 16'(alu_d_wr_en), 16'd0);
        tick(); tick();
        chk("c2_d_wr_q3", 16'(alu_d_wr_en), 16'd0);
        tick();
        chk("c2_d_wr_q4", 16'(alu_d_wr_en), 16'd1);
        chk("c2_st_wr_q4", 16'(alu_status_wr_en), 16'd0);
        tick();

        // cycle 3: ADDWF 0x20,1
        chk("c3_op", 16'(alu_op), 16'(OP_ADD));
        chk("c3_rf_addr", 16'(rf_addr), 16'h0020);
        chk("c3_d", 16'(alu_d), 16'd1);
        chk("c3_lit_sel", 16'(alu_lit_sel), 16'd0);
        to_q4();
        chk("c3_st_wr_q4", 16'(alu_status_wr_en), 16'd1);
        chk("c3_d_wr_q4", 16'(alu_d_wr_en), 16'd1);
        tick();

        // cycles 4..6: NOPs at 2..4; cycle 7: GOTO 0x123 with pclath_hi=10
        repeat (12) tick();
        chk("goto_pm_addr", 16'(pm_addr), 16'h0006);
        to_q4();
        chk("goto_d_wr", 16'(alu_d_wr_en), 16'd0);
        tick();
        chk("goto_target", 16'(pm_addr), 16'h1123);
        pclath_hi = 2'b00;
        to_q4();
        chk("goto_flush_op", 16'(alu_op), 16'(OP_PASSW));
        chk("goto_flush_d_wr", 16'(alu_d_wr_en), 16'd0);
        chk("goto_flush_st_wr", 16'(alu_status_wr_en), 16'd0);
        tick();
        // word at 0x1123 executes (GOTO 0x010)
        chk("exec_1123_pm", 16'(pm_addr), 16'h1124);
        repeat (4) tick();
        chk("goto2_target", 16'(pm_addr), 16'h0010);
        repeat (4) tick();

        // CALL 0x040 at 0x010
        t0 = clk_count;
        chk("call_pm_addr", 16'(pm_addr), 16'h0011);
        chk("call_push_q1", 16'(stack_push), 16'd0);
        to_q4();
        chk("call_push_q4", 16'(stack_push), 16'd1);
        chk("call_push_addr", 16'(stack_push_addr), 16'h0011);
        chk("call_d_wr", 16'(alu_d_wr_en), 16'd0);
        tick();
        chk("call_push_after", 16'(stack_push), 16'd0);
        chk("call_target", 16'(pm_addr), 16'h0040);
        repeat (4) tick();

        // RETURN at 0x040
        chk("call_cost_clocks", 16'(clk_count - t0), 16'd8);
        t0 = clk_count;
        chk("ret_pop_q1", 16'(stack_pop), 16'd0);
        to_q4();
        chk("ret_pop_q4", 16'(stack_pop), 16'd1);
        chk("ret_d_wr", 16'(alu_d_wr_en), 16'd0);
        tick();
        chk("ret_pop_after", 16'(stack_pop), 16'd0);
        chk("ret_target", 16'(pm_addr), 16'h0011);
        repeat (4) tick();

        // DECFSZ at 0x011 with zero result: skip 0x012
        chk("ret_cost_clocks", 16'(clk_count - t0), 16'd8);
        chk("dfsz_op", 16'(alu_op), 16'(OP_DEC));
        chk("dfsz_pm_addr", 16'(pm_addr), 16'h0012);
        to_q4();
        alu_z_res = 1'b1;
        chk("dfsz_st_wr", 16'(alu_status_wr_en), 16'd0);
        chk("dfsz_d_wr", 16'(alu_d_wr_en), 16'd1);
        tick();
        alu_z_res = 1'b0;
        chk("dfsz_skip_pm", 16'(pm_addr), 16'h0013);
        to_q4();
        chk("dfsz_skip_d_wr", 16'(alu_d_wr_en), 16'd0);
        tick();
        // DECFSZ at 0x013 with non-zero result: no skip
        chk("dfsz2_op", 16'(alu_op), 16'(OP_DEC));
        repeat (4) tick();
        chk("noskip_pm", 16'(pm_addr), 16'h0015);
        chk("noskip_op", 16'(alu_op), 16'(OP_PASSLF));
        chk("noskip_literal", 16'(literal), 16'h0011);
        repeat (4) tick();

        // BTFSS 0x03,2 with bit-test hit
        chk("btfss_op", 16'(alu_op), 16'(OP_BS));
        to_q4();
        alu_bit_test_res = 1'b1;
        chk("btfss_d_wr", 16'(alu_d_wr_en), 16'd0);
        tick();
        alu_bit_test_res = 1'b0;
        chk("btfss_skip_pm", 16'(pm_addr), 16'h0017);
        repeat (4) tick();

        // BSF 0x03,5
        chk("bsf_op", 16'(alu_op), 16'(OP_BS));
        chk("bsf_b_in", 16'(alu_b_in), 16'd5);
        chk("bsf_d", 16'(alu_d), 16'd1);
        chk("bsf_rf_addr", 16'(rf_addr), 16'h0003);
        tick(); tick();
        chk("bsf_d_wr_q3", 16'(alu_d_wr_en), 16'd0);
        tick();
        chk("bsf_d_wr_q4", 16'(alu_d_wr_en), 16'd1);
        tick();
        repeat (4) tick();

        // ADDWF at 0x019, reset asserted during Q3
        chk("abort_op", 16'(alu_op), 16'(OP_ADD));
        tick(); tick();
        chk("abort_phase_q3", 16'(q_phase), 16'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_phase", 16'(q_phase), 16'd0);
        chk("abort_pm_addr", 16'(pm_addr), 16'h0000);
        chk("abort_op_nop", 16'(alu_op), 16'(OP_PASSW));
        tick(); tick();
        chk("abort_d_wr", 16'(alu_d_wr_en), 16'd0);
        chk("abort_st_wr", 16'(alu_status_wr_en), 16'd0);
        rst_n = 1'b1;
        chk("restart_pm", 16'(pm_addr), 16'h0000);
        to_q4();
        chk("restart_d_wr", 16'(alu_d_wr_en), 16'd0);
        tick();
        chk("restart_pm2", 16'(pm_addr), 16'h0001);
        chk("restart_op", 16'(alu_op), 16'(OP_PASSLF));
        chk("restart_literal", 16'(literal), 16'h005A);

        // Redirect word 1 to GOTO 0x7FF with pclath_hi=11 -> 0x1FFF, then wrap
        mem[13'h0001] = 14'h2FFF;
        pclath_hi = 2'b11;
        repeat (4) tick();
        chk("wrap_goto_pm", 16'(pm_addr), 16'h0002);
        repeat (4) tick();
        chk("wrap_target", 16'(pm_addr), 16'h1FFF);
        repeat (4) tick();
        chk("wrap_pm", 16'(pm_addr), 16'h0000);
        chk("wrap_literal", 16'(literal), 16'h0077);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
